// File: rtl/lvds_stream_packer_pkg.sv
// Shared sizing helpers for the LVDS stream packer and its beat FIFO.
package lvds_stream_packer_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result = result + 1;
    return result;
  endfunction

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range <= 1) ? 1 : clog2(range);
  endfunction

  function automatic int unsigned ratio(input int unsigned out_width, input int unsigned in_width);
    return out_width / in_width;
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Show-ahead synchronous FIFO; a write into a full FIFO is accepted only alongside a read.
module stream_sync_fifo
  import lvds_stream_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned AW = cnt_width(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);
  localparam int unsigned MEM_DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next_c;
  logic             wr_do_c;
  logic             rd_do_c;

  always_comb begin
    rd_do_c      = rd_en & ~empty;
    wr_do_c      = wr_en & (~full | rd_do_c);
    level_next_c = level + LW'(wr_do_c) - LW'(rd_do_c);
  end

  assign full    = (level == LW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr_do_c) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; level tracks writes minus reads with one extra bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
    end else begin
      if (wr_do_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_do_c) rd_ptr <= rd_ptr + AW'(1);
      level <= level_next_c;
      empty <= (level_next_c == '0);
    end
  end

endmodule

// File: rtl/lvds_stream_packer.sv
// Packs narrow LVDS samples into AXI-Stream beats, buffers them, and marks tlast every BURST_LEN beats.
module lvds_stream_packer
  import lvds_stream_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_enable,
  input  logic [IN_WIDTH-1:0]                i_data,
  input  logic                               i_valid,
  input  logic                               i_sof,
  output logic [OUT_WIDTH-1:0]               m_tdata,
  output logic                               m_tvalid,
  output logic                               m_tlast,
  input  logic                               m_tready,
  input  logic                               i_ovf_clr,
  output logic                               o_overflow,
  output logic [level_width(FIFO_DEPTH)-1:0] o_fifo_level
);

  localparam int unsigned RATIO  = ratio(OUT_WIDTH, IN_WIDTH);
  localparam int unsigned LANE_W = cnt_width(RATIO);
  localparam int unsigned BEAT_W = cnt_width(BURST_LEN);

  logic [LANE_W-1:0]    lane_cnt;
  logic [LANE_W-1:0]    lane_sel_c;
  logic [LANE_W-1:0]    lane_next_c;
  logic [OUT_WIDTH-1:0] partial;
  logic [OUT_WIDTH-1:0] word_c;
  logic                 take_c;
  logic                 complete_c;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 last_beat_c;
  logic                 pop_c;
  logic                 drop_c;
  logic [OUT_WIDTH-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Frame start restarts packing in lane 0 with an empty partial word.
  always_comb begin
    take_c     = i_valid & i_enable;
    lane_sel_c = i_sof ? '0 : lane_cnt;
    word_c     = i_sof ? '0 : partial;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (lane_sel_c == LANE_W'(i)) word_c[i*IN_WIDTH +: IN_WIDTH] = i_data;
    end
    complete_c  = take_c & (lane_sel_c == LANE_W'(RATIO - 1));
    lane_next_c = complete_c ? '0 : lane_sel_c + LANE_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_cnt <= '0;
      partial  <= '0;
    end else if (!i_enable) begin
      lane_cnt <= '0;
      partial  <= '0;
    end else if (take_c) begin
      lane_cnt <= lane_next_c;
      partial  <= complete_c ? '0 : word_c;
    end
  end

  stream_sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_en   (complete_c),
    .wr_data (word_c),
    .rd_en   (m_tready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_fifo_level)
  );

  always_comb begin
    pop_c       = m_tready & ~fifo_empty;
    drop_c      = complete_c & fifo_full & ~pop_c;
    last_beat_c = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  end

  assign m_tvalid = ~fifo_empty;
  assign m_tdata  = fifo_empty ? '0 : fifo_rd_data;
  assign m_tlast  = ~fifo_empty & last_beat_c;

  // Beat position within the burst; the clear wins over a same-cycle overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt   <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop_c) beat_cnt <= last_beat_c ? '0 : beat_cnt + BEAT_W'(1);
      if (i_ovf_clr)   o_overflow <= 1'b0;
      else if (drop_c) o_overflow <= 1'b1;
    end
  end

endmodule
